// File: rtl/de_scoreboard_pkg.sv
// Shared constants and bus layouts for the decode-stage pending-write scoreboard.
package de_scoreboard_pkg;

    localparam int REGNOBITS  = 5;
    localparam int REGWORDS   = 32;
    localparam int SB_CNTBITS = 2;

    // DE -> scoreboard decode fields, MSB first in this order.
    typedef struct packed {
        logic                 valid;
        logic [REGNOBITS-1:0] rs1;
        logic                 rs1_used;
        logic [REGNOBITS-1:0] rs2;
        logic                 rs2_used;
        logic [REGNOBITS-1:0] rd;
        logic                 wr;
    } from_DE_to_SB_t;

    // WB -> scoreboard register-write bus, MSB first in this order.
    typedef struct packed {
        logic                 valid;
        logic [REGNOBITS-1:0] rd;
    } from_WB_to_SB_t;

    localparam int DE_TO_SB_W = $bits(from_DE_to_SB_t);
    localparam int WB_TO_SB_W = $bits(from_WB_to_SB_t);

endpackage

// File: rtl/de_scoreboard_counter.sv
// One register's saturating pending-write counter with zero/max flags.
module sb_counter #(
    parameter int CNTBITS = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               dec,
    output logic [CNTBITS-1:0] cnt,
    output logic               zero,
    output logic               max,
    output logic               nxt_zero
);
    logic               inc_ok;
    logic               dec_ok;
    logic [CNTBITS-1:0] cnt_nxt;

    assign zero   = (cnt == '0);
    assign max    = (cnt == '1);
    // Never wrap: an increment at max or a decrement at zero is dropped.
    assign inc_ok = inc && !max;
    assign dec_ok = dec && !zero;

    // Next count; simultaneous inc and dec cancel.
    always_comb begin
        cnt_nxt = cnt;
        if (inc_ok && !dec_ok)
            cnt_nxt = cnt + 1'b1;
        else if (dec_ok && !inc_ok)
            cnt_nxt = cnt - 1'b1;
    end

    assign nxt_zero = (cnt_nxt == '0);

    // Counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

endmodule

// File: rtl/de_scoreboard.sv
// Per-register pending-write scoreboard: drives DE stall, accepts issues,
// retires writes from WB and offers a drain handshake for serialising ops.
module de_scoreboard
    import de_scoreboard_pkg::*;
#(
    parameter int REGWORDS  = de_scoreboard_pkg::REGWORDS,
    parameter int REGNOBITS = de_scoreboard_pkg::REGNOBITS,
    parameter int CNTBITS   = SB_CNTBITS,
    parameter int WB_BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [REGNOBITS-1:0] issue_rs1,
    input  logic                 issue_rs1_used,
    input  logic [REGNOBITS-1:0] issue_rs2,
    input  logic                 issue_rs2_used,
    input  logic [REGNOBITS-1:0] issue_rd,
    input  logic                 issue_wr,
    input  logic                 flush,
    input  logic                 wb_valid,
    input  logic [REGNOBITS-1:0] wb_rd,
    input  logic                 drain_req,
    output logic                 stall,
    output logic                 issue_fire,
    output logic                 drain_ack,
    output logic [REGWORDS-1:0]  busy_vec,
    output logic                 err_underflow
);
    from_DE_to_SB_t de;
    from_WB_to_SB_t wb;

    assign de = '{valid: issue_valid, rs1: issue_rs1, rs1_used: issue_rs1_used,
                  rs2: issue_rs2, rs2_used: issue_rs2_used, rd: issue_rd, wr: issue_wr};
    assign wb = '{valid: wb_valid, rd: wb_rd};

    // Register 0 is never tracked: constant idle flags in slot 0.
    logic [REGWORDS-1:1][CNTBITS-1:0] cnt;
    logic [REGWORDS-1:1]              inc_vec;
    logic [REGWORDS-1:1]              dec_vec;
    logic [REGWORDS-1:0]              zero_vec;
    logic [REGWORDS-1:0]              max_vec;
    logic [REGWORDS-1:0]              nxt_zero_vec;
    logic [REGWORDS-1:0]              busy_eff;

    assign zero_vec[0]     = 1'b1;
    assign max_vec[0]      = 1'b0;
    assign nxt_zero_vec[0] = 1'b1;
    assign busy_eff[0]     = 1'b0;

    genvar r;
    generate
        for (r = 1; r < REGWORDS; r++) begin : g_reg
            assign inc_vec[r] = issue_fire && de.wr && (de.rd == REGNOBITS'(r));
            assign dec_vec[r] = wb.valid && (wb.rd == REGNOBITS'(r));
            // A WB retiring the last pending write is visible to this cycle's reads.
            assign busy_eff[r] = !zero_vec[r] &&
                                 !((WB_BYPASS != 0) && dec_vec[r] && (cnt[r] == CNTBITS'(1)));

            sb_counter #(.CNTBITS(CNTBITS)) u_cnt (
                .clk      (clk),
                .reset    (reset),
                .inc      (inc_vec[r]),
                .dec      (dec_vec[r]),
                .cnt      (cnt[r]),
                .zero     (zero_vec[r]),
                .max      (max_vec[r]),
                .nxt_zero (nxt_zero_vec[r])
            );
        end
    endgenerate

    logic src_hit;
    logic waw_sat;
    logic drain_block;

    assign src_hit     = (de.rs1_used && busy_eff[de.rs1]) || (de.rs2_used && busy_eff[de.rs2]);
    assign waw_sat     = de.wr && max_vec[de.rd];
    assign drain_block = drain_req && !(&zero_vec);

    // Stall and fire are suppressed while reset is held; flush squashes the issue.
    assign stall      = reset && de.valid && (src_hit || waw_sat || drain_block);
    assign issue_fire = reset && de.valid && !stall && !flush;

    assign busy_vec = ~zero_vec;

    // Drain acknowledge tracks whether every counter is zero after this edge.
    always_ff @(posedge clk) begin
        if (!reset)
            drain_ack <= 1'b1;
        else
            drain_ack <= &nxt_zero_vec;
    end

    // Sticky flag for a WB to a register with nothing pending.
    always_ff @(posedge clk) begin
        if (!reset)
            err_underflow <= 1'b0;
        else if (wb.valid && (wb.rd != '0) && zero_vec[wb.rd])
            err_underflow <= 1'b1;
    end

endmodule

// File: tb/tb_de_scoreboard.sv
// Directed plus randomized bench for de_scoreboard with a count-array reference model.
module tb_de_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, issue_rs1_used, issue_rs2_used, issue_wr;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd, wb_rd;
    logic        flush, wb_valid, drain_req;
    logic        stall, issue_fire, drain_ack, err_underflow;
    logic [31:0] busy_vec;

    int cnt_m[32];
    bit err_m;
    int vectors;
    int miscompares;

    always #5 clk = ~clk;

    de_scoreboard dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs1_used(issue_rs1_used),
        .issue_rs2(issue_rs2), .issue_rs2_used(issue_rs2_used), .issue_rd(issue_rd),
        .issue_wr(issue_wr), .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .drain_req(drain_req), .stall(stall), .issue_fire(issue_fire),
        .drain_ack(drain_ack), .busy_vec(busy_vec), .err_underflow(err_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit src_busy(input logic used, input logic [4:0] s);
        if (!used || s == 0 || cnt_m[s] == 0) return 0;
        if (wb_valid && wb_rd == s && cnt_m[s] == 1) return 0;
        return 1;
    endfunction

    task automatic idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs1_used = 0; issue_rs2 = 0;
        issue_rs2_used = 0; issue_rd = 0; issue_wr = 0; flush = 0;
        wb_valid = 0; wb_rd = 0; drain_req = 0;
    endtask

    task automatic iss(input logic [4:0] rs1, input logic u1, input logic [4:0] rd, input logic wr);
        issue_valid = 1; issue_rs1 = rs1; issue_rs1_used = u1;
        issue_rs2 = 0; issue_rs2_used = 0; issue_rd = rd; issue_wr = wr;
    endtask

    // Check all outputs against the model for the current inputs, then clock once.
    task automatic cycle();
        bit es, ef, any;
        logic [31:0] eb;
        int pre[32];
        #1;
        any = 0;
        eb  = '0;
        for (int i = 1; i < 32; i++) begin
            if (cnt_m[i] != 0) begin any = 1; eb[i] = 1'b1; end
        end
        es = reset && issue_valid &&
             (src_busy(issue_rs1_used, issue_rs1) || src_busy(issue_rs2_used, issue_rs2) ||
              (issue_wr && issue_rd != 0 && cnt_m[issue_rd] == 3) || (drain_req && any));
        ef = reset && issue_valid && !es && !flush;
        chk("stall", 32'(stall), 32'(es));
        chk("issue_fire", 32'(issue_fire), 32'(ef));
        chk("busy_vec", busy_vec, eb);
        chk("drain_ack", 32'(drain_ack), 32'(!any));
        chk("err_underflow", 32'(err_underflow), 32'(err_m));
        @(posedge clk);
        pre = cnt_m;
        if (!reset) begin
            foreach (cnt_m[i]) cnt_m[i] = 0;
            err_m = 0;
        end else begin
            if (ef && issue_wr && issue_rd != 0) cnt_m[issue_rd] = cnt_m[issue_rd] + 1;
            if (wb_valid && wb_rd != 0) begin
                if (pre[wb_rd] == 0) err_m = 1;
                else cnt_m[wb_rd] = cnt_m[wb_rd] - 1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        vectors = 0; miscompares = 0; err_m = 0;
        foreach (cnt_m[i]) cnt_m[i] = 0;
        idle();
        reset = 0;
        @(negedge clk);

        // Reset held with a valid writing instruction.
        iss(0, 0, 5, 1);
        #1;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_fire", 32'(issue_fire), 0);
        chk("rst_drain_ack", 32'(drain_ack), 1);
        cycle(); cycle();
        chk("rst_busy", busy_vec, 0);

        // RAW on x5, resolved by WB bypass.
        reset = 1; idle();
        iss(0, 0, 5, 1); cycle();
        iss(5, 1, 6, 0); #1; chk("raw_stall", 32'(stall), 1); cycle(); cycle();
        wb_valid = 1; wb_rd = 5; #1;
        chk("raw_bypass_stall", 32'(stall), 0);
        chk("raw_bypass_fire", 32'(issue_fire), 1);
        cycle();
        idle(); #1; chk("raw_busy5_clear", 32'(busy_vec[5]), 0); cycle();

        // WAW saturation on x7.
        iss(0, 0, 7, 1); cycle(); cycle(); cycle();
        #1; chk("waw_sat_stall", 32'(stall), 1);
        wb_valid = 1; wb_rd = 7; cycle();
        wb_valid = 0; #1; chk("waw_fourth_fire", 32'(issue_fire), 1); cycle();
        idle(); wb_valid = 1; wb_rd = 7; cycle(); cycle(); cycle();

        // Flush squashes the issue.
        idle(); iss(0, 0, 9, 1); flush = 1;
        #1; chk("flush_fire", 32'(issue_fire), 0); cycle();
        idle(); #1; chk("flush_busy9", 32'(busy_vec[9]), 0); cycle();

        // Simultaneous inc/dec on x3.
        iss(0, 0, 3, 1); cycle();
        wb_valid = 1; wb_rd = 3; cycle();
        idle(); #1; chk("incdec_busy3", 32'(busy_vec[3]), 1);
        wb_valid = 1; wb_rd = 3; cycle();

        // Underflow and x0.
        idle(); wb_valid = 1; wb_rd = 4; cycle();
        idle(); #1; chk("underflow_set", 32'(err_underflow), 1); cycle();
        iss(0, 1, 0, 1); #1; chk("x0_stall", 32'(stall), 0); cycle();
        idle(); #1; chk("x0_busy", 32'(busy_vec[0]), 0); cycle();

        // Drain behind a pending write to x2.
        iss(0, 0, 2, 1); cycle();
        iss(11, 1, 10, 1); drain_req = 1;
        #1; chk("drain_stall", 32'(stall), 1); cycle();
        wb_valid = 1; wb_rd = 2; cycle();
        wb_valid = 0; #1;
        chk("drain_ack_set", 32'(drain_ack), 1);
        chk("drain_fire", 32'(issue_fire), 1);
        cycle();

        // Randomized traffic on a small register window, with occasional reset.
        for (int n = 0; n < 500; n++) begin
            reset          = ($urandom_range(99) >= 3);
            issue_valid    = ($urandom_range(99) < 70);
            issue_rs1      = 5'($urandom_range(7));
            issue_rs1_used = 1'($urandom);
            issue_rs2      = 5'($urandom_range(7));
            issue_rs2_used = 1'($urandom);
            issue_rd       = 5'($urandom_range(7));
            issue_wr       = 1'($urandom);
            flush          = ($urandom_range(99) < 10);
            wb_valid       = ($urandom_range(99) < 40);
            wb_rd          = 5'($urandom_range(7));
            drain_req      = ($urandom_range(99) < 10);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/de_scoreboard.md
Name: de_scoreboard

Overview:
- Replaces the per-stage destination-comparator hazard check in decode with a per-register pending-write scoreboard.
- Counts in-flight register writes between DE issue and WB, and drives the DE stall that freezes FE.
- Provides a drain handshake so decode can serialize instructions such as CSRW behind all outstanding writes.
- Sits beside DE_STAGE; fed by DE decode fields, the AGEX flush signal and the WB register-write bus.

Parameters:
- REGWORDS, 32, number of architectural registers.
- REGNOBITS, 5, register index width.
- CNTBITS, 2, per-register pending counter width; at most 2^CNTBITS-1 writes in flight per register.
- WB_BYPASS, 1, when 1 a same-cycle WB retiring the last pending write to a source does not cause a stall (regfile is written on negedge).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- issue_valid  in  1  DE holds a valid decoded instruction this cycle.
- issue_rs1  in  REGNOBITS  source 1 index.
- issue_rs1_used  in  1  source 1 is read.
- issue_rs2  in  REGNOBITS  source 2 index.
- issue_rs2_used  in  1  source 2 is read.
- issue_rd  in  REGNOBITS  destination index.
- issue_wr  in  1  instruction writes rd.
- flush  in  1  branch mispredict from AGEX; squashes the DE instruction.
- wb_valid  in  1  WB writes a register this cycle.
- wb_rd  in  REGNOBITS  WB destination.
- drain_req  in  1  level request: hold issue until no writes are pending.
- stall  out  1  combinational DE stall to FE.
- issue_fire  out  1  combinational; the instruction is accepted into DE latch.
- drain_ack  out  1  registered; all counters zero.
- busy_vec  out  REGWORDS  registered; bit r = (cnt[r] != 0).
- err_underflow  out  1  sticky; WB to a register with cnt == 0.

Behaviour:
- State: cnt[1..REGWORDS-1], CNTBITS each. Register 0 is never tracked; its index never stalls, sets or clears.
- Reset (reset == 0 at posedge): all cnt = 0, busy_vec = 0, drain_ack = 1, err_underflow = 0.
- While reset is asserted: stall = 0, issue_fire = 0.
- busy_eff(r) = cnt[r] != 0, except when WB_BYPASS && wb_valid && wb_rd == r && cnt[r] == 1, where busy_eff(r) = 0.
- stall = issue_valid && (src_hit || waw_sat || drain_block), where:
  - src_hit = (rs1_used && rs1 != 0 && busy_eff(rs1)) || the same term for rs2.
  - waw_sat = issue_wr && rd != 0 && cnt[rd] == max.
  - drain_block = drain_req && any cnt != 0.
- issue_fire = issue_valid && !stall && !flush. Flush wins; a squashed instruction never increments.
- Per register r, at posedge:
  - inc = issue_fire && issue_wr && issue_rd == r.
  - dec = wb_valid && wb_rd == r && cnt[r] != 0.
  - cnt[r] next = cnt + inc - dec. Simultaneous inc and dec leaves cnt unchanged.
- Saturation: counters never wrap; waw_sat prevents an increment at max.
- wb_valid to r with cnt[r] == 0: no change; err_underflow set and held until reset.
- Latency: an issue sets busy from the next cycle. Back-to-back dependents stall one or more cycles until the WB that clears the count.
- drain_ack = registered (all next cnt == 0).
  - drain_req with drain_ack == 1 issues without stall.
  - While drain_req is high, no further issue occurs until drain_ack.
- rs1 == rs2 == rd is allowed; sources are checked against the pre-update counts.
- Reset mid-operation: all pending state is discarded. The pipeline is reset in the same cycle.

Decomposition:
- Shared package / define.vh: REGNOBITS, REGWORDS, SB_CNTBITS, and the from_DE_to_SB / from_WB_to_SB bus widths with their field order.
- One natural sub-module, sb_counter: a single register's CNTBITS saturating up/down counter with inc, dec, zero and max flags. It is instantiated REGWORDS-1 times in a generate loop.

Test Plan:
- Reset: hold reset=0 for 2 cycles with issue_valid=1, rd=5 -> stall=0, issue_fire=0, busy_vec=0, drain_ack=1.
- RAW: issue rd=5; next cycle issue rs1=5 -> stall=1 until wb_valid with wb_rd=5. In that WB cycle, with WB_BYPASS=1 -> stall=0 and issue_fire=1; busy_vec[5] clears the next cycle.
- WAW saturation (CNTBITS=2): three issues with rd=7 and no WB -> cnt[7]=3. A fourth with rd=7 -> stall=1. A single WB to 7 -> cnt=2 and the fourth issues.
- Flush: issue_valid=1, rd=9, flush=1 -> issue_fire=0 and busy_vec[9] stays 0.
- Simultaneous inc/dec: cnt[3]=1; issue rd=3 together with WB rd=3 -> cnt[3] stays 1 and busy_vec[3]=1.
- Underflow and x0: WB rd=4 with cnt=0 -> err_underflow=1 (sticky). Issue rs1=0, rd=0 -> never stalls and busy_vec[0]=0.
- Drain: cnt[2]=1, drain_req=1, independent instruction -> stall=1. After WB rd=2 -> drain_ack=1 and the instruction issues.
